// File: rtl/mux_stream_nto1_if.sv
// Stream bundle around mux_stream_nto1: N producer channels in, one consumer out.
interface mux_stream_nto1_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready;

    // Environment view: drives producer streams, select and consumer ready
    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Multiplexer view
    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_stream_nto1.sv
// N-to-1 streaming multiplexer with valid/ready handshake and a registered
// output stage. MODE=0 grants the channel named by sel; MODE=1 grants
// round-robin with up to BURST consecutive beats per channel.
module mux_stream_nto1 #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int MODE  = 0,
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_stream_nto1_if.slave bus
);
    localparam int SW = $clog2(N);
    typedef logic [SW-1:0] ch_t;

    logic         w_load;
    logic         w_gnt_vld;
    ch_t          w_gnt;
    logic [W-1:0] w_gnt_data;
    logic         w_xfer;
    logic [N-1:0] w_in_ready;

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    ch_t          r_out_ch;
    ch_t          r_rr_ptr;
    logic [7:0]   r_burst_cnt;

    // The output register may accept a new beat when empty or being drained
    assign w_load = !r_out_valid || bus.out_ready;
    assign w_xfer = rst_n && w_load && w_gnt_vld;

    // Grant selection and data mux for the granted channel
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt      = '0;
        w_gnt_data = '0;
        if (MODE == 0) begin
            // sel values >= N match no channel, so they yield no grant
            for (int unsigned c = 0; c < N; c++) begin
                if (bus.sel == ch_t'(c) && bus.in_valid[c]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = ch_t'(c);
                end
            end
        end else begin
            // Circular search from rr_ptr done as two ascending passes:
            // channels at/after the pointer first, then those before it.
            for (int unsigned c = 0; c < N; c++) begin
                if (!w_gnt_vld && bus.in_valid[c] && r_rr_ptr <= ch_t'(c)) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = ch_t'(c);
                end
            end
            for (int unsigned c = 0; c < N; c++) begin
                if (!w_gnt_vld && bus.in_valid[c] && r_rr_ptr > ch_t'(c)) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = ch_t'(c);
                end
            end
        end
        for (int unsigned c = 0; c < N; c++) begin
            if (w_gnt == ch_t'(c)) begin
                w_gnt_data = bus.in_data[c*W +: W];
            end
        end
    end

    // One-hot ready to the granted channel; silent during reset or stall
    always_comb begin
        w_in_ready = '0;
        for (int unsigned c = 0; c < N; c++) begin
            w_in_ready[c] = w_xfer && (w_gnt == ch_t'(c));
        end
    end

    // Output register: load on input transfer, empty on drain, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_ch    <= w_gnt;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Round-robin pointer and burst counter, advanced only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else if (MODE != 0 && w_xfer) begin
            if (w_gnt == r_rr_ptr && int'(r_burst_cnt) + 1 < BURST) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end else begin
                r_rr_ptr    <= (int'(w_gnt) == N - 1) ? '0 : w_gnt + ch_t'(1);
                r_burst_cnt <= '0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_mux_stream_nto1.sv
// Bench for mux_stream_nto1: four instances (select N=4, select N=6,
// round-robin N=4 BURST=1, round-robin N=5 BURST=3) driven through shared
// per-instance stimulus arrays and checked against a queue-free cycle model.
module tb_mux_stream_nto1;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mux_stream_nto1_if #(.N(4), .W(8)) if_s4 ();
    mux_stream_nto1_if #(.N(6), .W(8)) if_s6 ();
    mux_stream_nto1_if #(.N(4), .W(8)) if_r1 ();
    mux_stream_nto1_if #(.N(5), .W(8)) if_r3 ();

    mux_stream_nto1 #(.N(4), .W(8), .MODE(0), .BURST(1)) u_s4 (.clk(clk), .rst_n(rst_n), .bus(if_s4));
    mux_stream_nto1 #(.N(6), .W(8), .MODE(0), .BURST(1)) u_s6 (.clk(clk), .rst_n(rst_n), .bus(if_s6));
    mux_stream_nto1 #(.N(4), .W(8), .MODE(1), .BURST(1)) u_r1 (.clk(clk), .rst_n(rst_n), .bus(if_r1));
    mux_stream_nto1 #(.N(5), .W(8), .MODE(1), .BURST(3)) u_r3 (.clk(clk), .rst_n(rst_n), .bus(if_r3));

    // Per-instance stimulus (index 0..3 = s4, s6, r1, r3) and observed outputs
    logic [5:0]  t_valid  [4];
    logic [47:0] t_data   [4];
    logic [2:0]  t_sel    [4];
    logic        t_oready [4];
    logic [5:0]  t_iready [4];
    logic        t_ovalid [4];
    logic [7:0]  t_odata  [4];
    logic [2:0]  t_och    [4];

    assign if_s4.in_valid  = t_valid[0][3:0];
    assign if_s4.in_data   = t_data[0][31:0];
    assign if_s4.sel       = t_sel[0][1:0];
    assign if_s4.out_ready = t_oready[0];
    assign t_iready[0]     = {2'b00, if_s4.in_ready};
    assign t_ovalid[0]     = if_s4.out_valid;
    assign t_odata[0]      = if_s4.out_data;
    assign t_och[0]        = {1'b0, if_s4.out_ch};

    assign if_s6.in_valid  = t_valid[1];
    assign if_s6.in_data   = t_data[1];
    assign if_s6.sel       = t_sel[1];
    assign if_s6.out_ready = t_oready[1];
    assign t_iready[1]     = if_s6.in_ready;
    assign t_ovalid[1]     = if_s6.out_valid;
    assign t_odata[1]      = if_s6.out_data;
    assign t_och[1]        = if_s6.out_ch;

    assign if_r1.in_valid  = t_valid[2][3:0];
    assign if_r1.in_data   = t_data[2][31:0];
    assign if_r1.sel       = 2'b00;
    assign if_r1.out_ready = t_oready[2];
    assign t_iready[2]     = {2'b00, if_r1.in_ready};
    assign t_ovalid[2]     = if_r1.out_valid;
    assign t_odata[2]      = if_r1.out_data;
    assign t_och[2]        = {1'b0, if_r1.out_ch};

    assign if_r3.in_valid  = t_valid[3][4:0];
    assign if_r3.in_data   = t_data[3][39:0];
    assign if_r3.sel       = 3'b000;
    assign if_r3.out_ready = t_oready[3];
    assign t_iready[3]     = {1'b0, if_r3.in_ready};
    assign t_ovalid[3]     = if_r3.out_valid;
    assign t_odata[3]      = if_r3.out_data;
    assign t_och[3]        = if_r3.out_ch;

    // Reference model state
    int         m_ptr [4];
    int         m_cnt [4];
    bit         m_ov  [4];
    logic [7:0] m_od  [4];
    int         m_och [4];

    function automatic int n_of(input int j);
        case (j)
            0:       return 4;
            1:       return 6;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int mode_of(input int j);
        return (j >= 2) ? 1 : 0;
    endfunction

    function automatic int burst_of(input int j);
        return (j == 3) ? 3 : 1;
    endfunction

    // Which channel the rules grant this cycle (ignoring load)
    function automatic void ref_grant(input int j, output bit gv, output int g);
        int n;
        n  = n_of(j);
        gv = 1'b0;
        g  = 0;
        if (mode_of(j) == 0) begin
            if (int'(t_sel[j]) < n) begin
                if (t_valid[j][t_sel[j]] === 1'b1) begin
                    gv = 1'b1;
                    g  = int'(t_sel[j]);
                end
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (m_ptr[j] + k) % n;
                if (!gv && t_valid[j][c] === 1'b1) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    // Advance the model across one rising edge
    function automatic void ref_commit(input int j);
        bit gv;
        int g;
        bit load;
        load = !m_ov[j] || t_oready[j];
        ref_grant(j, gv, g);
        if (load && gv) begin
            m_ov[j]  = 1'b1;
            m_od[j]  = t_data[j][g*8 +: 8];
            m_och[j] = g;
            if (mode_of(j) == 1) begin
                if (g == m_ptr[j] && m_cnt[j] + 1 < burst_of(j)) begin
                    m_cnt[j] = m_cnt[j] + 1;
                end else begin
                    m_ptr[j] = (g + 1) % n_of(j);
                    m_cnt[j] = 0;
                end
            end
        end else if (t_oready[j]) begin
            m_ov[j] = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int j = 0; j < 4; j++) begin
            t_valid[j]  = '0;
            t_data[j]   = '0;
            t_sel[j]    = '0;
            t_oready[j] = 1'b1;
            m_ptr[j]    = 0;
            m_cnt[j]    = 0;
            m_ov[j]     = 1'b0;
            m_od[j]     = '0;
            m_och[j]    = 0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 4; j++) begin
            t_valid[j]  = 6'h3F;
            t_data[j]   = 48'h1234_5678_9ABC;
            t_sel[j]    = 3'd0;
            t_oready[j] = 1'b1;
        end
        rst_n = 1'b0;
        #12;
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (t_iready[j] !== 6'd0) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 0", j, t_iready[j]); end
            n_checks++; if (t_ovalid[j] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", j, t_ovalid[j]); end
            n_checks++; if (t_odata[j] !== 8'h00) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %h expected 00", j, t_odata[j]); end
            n_checks++; if (t_och[j] !== 3'd0) begin n_fail++; $display("FAIL reset_out_ch[%0d]: got %0d expected 0", j, t_och[j]); end
        end
    endtask

    task automatic test_select_basic();
        do_reset();
        t_data[0]   = {16'h0, 8'h44, 8'hA5, 8'h22, 8'h11};
        t_valid[0]  = 6'b000100;
        t_sel[0]    = 3'd2;
        t_oready[0] = 1'b1;
        #3;
        n_checks++; if (t_iready[0] !== 6'b000100) begin n_fail++; $display("FAIL sel_basic_in_ready: got %b expected 000100", t_iready[0]); end
        tick();
        n_checks++; if (t_ovalid[0] !== 1'b1) begin n_fail++; $display("FAIL sel_basic_out_valid: got %b expected 1", t_ovalid[0]); end
        n_checks++; if (t_odata[0] !== 8'hA5) begin n_fail++; $display("FAIL sel_basic_out_data: got %h expected a5", t_odata[0]); end
        n_checks++; if (t_och[0] !== 3'd2) begin n_fail++; $display("FAIL sel_basic_out_ch: got %0d expected 2", t_och[0]); end
    endtask

    task automatic test_select_no_grant();
        // selected channel not valid: no grant, register drains, data holds
        t_sel[0] = 3'd1;
        #3;
        n_checks++; if (t_iready[0] !== 6'd0) begin n_fail++; $display("FAIL sel_invalid_in_ready: got %b expected 0", t_iready[0]); end
        tick();
        n_checks++; if (t_ovalid[0] !== 1'b0) begin n_fail++; $display("FAIL sel_drain_out_valid: got %b expected 0", t_ovalid[0]); end
        n_checks++; if (t_odata[0] !== 8'hA5) begin n_fail++; $display("FAIL sel_drain_hold_data: got %h expected a5", t_odata[0]); end
        n_checks++; if (t_och[0] !== 3'd2) begin n_fail++; $display("FAIL sel_drain_hold_ch: got %0d expected 2", t_och[0]); end
        // N=6: out-of-range sel values 6 and 7 grant nothing
        t_valid[1]  = 6'h3F;
        t_data[1]   = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        t_oready[1] = 1'b1;
        for (int s = 6; s < 8; s++) begin
            t_sel[1] = 3'(s);
            #3;
            n_checks++; if (t_iready[1] !== 6'd0) begin n_fail++; $display("FAIL sel_range_in_ready sel=%0d: got %b expected 0", s, t_iready[1]); end
            tick();
            n_checks++; if (t_ovalid[1] !== 1'b0) begin n_fail++; $display("FAIL sel_range_out_valid sel=%0d: got %b expected 0", s, t_ovalid[1]); end
        end
        // highest legal channel
        t_sel[1] = 3'd5;
        #3;
        n_checks++; if (t_iready[1] !== 6'b100000) begin n_fail++; $display("FAIL sel_top_in_ready: got %b expected 100000", t_iready[1]); end
        tick();
        n_checks++; if (t_odata[1] !== 8'h66 || t_och[1] !== 3'd5 || t_ovalid[1] !== 1'b1) begin
            n_fail++; $display("FAIL sel_top_out: got v=%b d=%h ch=%0d expected v=1 d=66 ch=5", t_ovalid[1], t_odata[1], t_och[1]);
        end
    endtask

    task automatic test_rr_burst1();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        t_data[2]  = {16'h0, 8'h13, 8'h12, 8'h11, 8'h10};
        t_valid[2] = 6'h0F;
        #3;
        n_checks++; if (t_iready[2] !== 6'b000001) begin n_fail++; $display("FAIL rr1_first_in_ready: got %b expected 000001", t_iready[2]); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (t_och[2] !== 3'(exp_seq[i]) || t_odata[2] !== 8'(8'h10 + exp_seq[i])) begin
                n_fail++; $display("FAIL rr1_seq beat %0d: got ch=%0d d=%h expected ch=%0d d=%h", i, t_och[2], t_odata[2], exp_seq[i], 8'(8'h10 + exp_seq[i]));
            end
        end
    endtask

    task automatic test_rr_burst3();
        int seq_all  [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 0};
        int seq_drop [12] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 4, 4, 0};
        do_reset();
        t_data[3]  = {8'h0, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
        t_valid[3] = 6'h1F;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++; if (t_och[3] !== 3'(seq_all[i])) begin n_fail++; $display("FAIL rr3_seq beat %0d: got %0d expected %0d", i, t_och[3], seq_all[i]); end
        end
        // ch1 drops valid after its first beat
        do_reset();
        t_data[3]  = {8'h0, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
        t_valid[3] = 6'h1F;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) begin
                t_valid[3] = 6'h1D;
                #3;
                n_checks++; if (t_iready[3] !== 6'b000100) begin n_fail++; $display("FAIL rr3_drop_in_ready: got %b expected 000100", t_iready[3]); end
            end
            tick();
            n_checks++; if (t_och[3] !== 3'(seq_drop[i])) begin n_fail++; $display("FAIL rr3_drop_seq beat %0d: got %0d expected %0d", i, t_och[3], seq_drop[i]); end
        end
    endtask

    task automatic test_backpressure();
        int delivered;
        do_reset();
        t_data[2]   = {16'h0, 8'h33, 8'h77, 8'h5A, 8'h3C};
        t_valid[2]  = 6'b000001;
        t_oready[2] = 1'b1;
        tick();
        n_checks++; if (t_odata[2] !== 8'h3C || t_ovalid[2] !== 1'b1) begin n_fail++; $display("FAIL bp_load: got v=%b d=%h expected v=1 d=3c", t_ovalid[2], t_odata[2]); end
        t_oready[2] = 1'b0;
        t_valid[2]  = 6'h0F;
        for (int i = 0; i < 5; i++) begin
            #3;
            n_checks++; if (t_iready[2] !== 6'd0) begin n_fail++; $display("FAIL bp_in_ready stall %0d: got %b expected 0", i, t_iready[2]); end
            n_checks++; if (t_ovalid[2] !== 1'b1 || t_odata[2] !== 8'h3C) begin n_fail++; $display("FAIL bp_hold stall %0d: got v=%b d=%h expected v=1 d=3c", i, t_ovalid[2], t_odata[2]); end
            tick();
        end
        t_oready[2] = 1'b1;
        t_valid[2]  = 6'd0;
        delivered   = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            if (t_ovalid[2] === 1'b1 && t_oready[2]) delivered++;
            tick();
        end
        n_checks++; if (delivered !== 1) begin n_fail++; $display("FAIL bp_deliver_once: got %0d beats expected 1", delivered); end
        // pointer advanced only by the single accepted beat
        t_valid[2] = 6'h0F;
        #3;
        n_checks++; if (t_iready[2] !== 6'b000010) begin n_fail++; $display("FAIL bp_ptr_frozen: got %b expected 000010", t_iready[2]); end
        tick();
        n_checks++; if (t_och[2] !== 3'd1 || t_odata[2] !== 8'h5A) begin n_fail++; $display("FAIL bp_next_beat: got ch=%0d d=%h expected ch=1 d=5a", t_och[2], t_odata[2]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        t_data[2]  = {16'h0, 8'h13, 8'h12, 8'h11, 8'h10};
        t_data[3]  = {8'h0, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
        t_valid[2] = 6'h0F;
        t_valid[3] = 6'h1F;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int j = 2; j < 4; j++) begin
            n_checks++; if (t_ovalid[j] !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid[%0d]: got %b expected 0", j, t_ovalid[j]); end
            n_checks++; if (t_iready[j] !== 6'd0) begin n_fail++; $display("FAIL arst_in_ready[%0d]: got %b expected 0", j, t_iready[j]); end
            n_checks++; if (t_odata[j] !== 8'h00) begin n_fail++; $display("FAIL arst_out_data[%0d]: got %h expected 00", j, t_odata[j]); end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        n_checks++; if (t_iready[2] !== 6'b000001) begin n_fail++; $display("FAIL arst_first_grant[2]: got %b expected 000001", t_iready[2]); end
        n_checks++; if (t_iready[3] !== 6'b000001) begin n_fail++; $display("FAIL arst_first_grant[3]: got %b expected 000001", t_iready[3]); end
        tick();
        for (int j = 2; j < 4; j++) begin
            n_checks++; if (t_ovalid[j] !== 1'b1 || t_och[j] !== 3'd0) begin n_fail++; $display("FAIL arst_first_beat[%0d]: got v=%b ch=%0d expected v=1 ch=0", j, t_ovalid[j], t_och[j]); end
        end
    endtask

    task automatic test_random(input int j, input int cycles);
        bit         gv;
        int         g;
        bit         load;
        logic [5:0] exp_rdy;
        do_reset();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            t_valid[j]  = 6'($urandom);
            t_data[j]   = {16'($urandom), 32'($urandom)};
            t_sel[j]    = (j == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            t_oready[j] = ($urandom_range(0, 3) != 0);
            #3;
            load = !m_ov[j] || t_oready[j];
            ref_grant(j, gv, g);
            exp_rdy = (load && gv) ? 6'(1 << g) : 6'd0;
            n_checks++; if (t_iready[j] !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready[%0d] cyc %0d: got %b expected %b", j, cyc, t_iready[j], exp_rdy); end
            n_checks++; if (t_ovalid[j] !== m_ov[j]) begin n_fail++; $display("FAIL rand_out_valid[%0d] cyc %0d: got %b expected %b", j, cyc, t_ovalid[j], m_ov[j]); end
            n_checks++; if (t_odata[j] !== m_od[j]) begin n_fail++; $display("FAIL rand_out_data[%0d] cyc %0d: got %h expected %h", j, cyc, t_odata[j], m_od[j]); end
            n_checks++; if (t_och[j] !== 3'(m_och[j])) begin n_fail++; $display("FAIL rand_out_ch[%0d] cyc %0d: got %0d expected %0d", j, cyc, t_och[j], m_och[j]); end
            ref_commit(j);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_select_basic();
        test_select_no_grant();
        test_rr_burst1();
        test_rr_burst3();
        test_backpressure();
        test_async_reset();
        for (int j = 0; j < 4; j++) test_random(j, 200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
